ltc26xx_chain_writer: RTL and testbench

Parametrised successor to the single-command LTC2600 SPI writer. It buffers DAC commands in a FIFO and drives a daisy-chain of N LTC2600/2610/2620-family DACs over one SPI bus (sck/sdi/csb). The data width and SCK rate are configurable. It sits behind the IPIF parameter block: the register side pushes commands, and this block serialises one chain frame per command.

---
 rtl/ltc26xx_chain_writer.sv | 179 +++++++++++++++++
 tb/tb_ltc26xx_chain_writer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ltc26xx_chain_writer.sv
// LTC2600/2610/2620 daisy-chain SPI writer: a command FIFO feeding one
// csb-framed SPI transfer of 24*N_DEVICES bits per queued command.
module ltc26xx_chain_writer #(
  parameter int DATA_WIDTH = 16,
  parameter int N_DEVICES  = 1,
  parameter int FIFO_DEPTH = 8,
  parameter int SCK_DIV    = 2,
  parameter int CS_GAP     = 4
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  cmd_valid,
  output logic                                  cmd_ready,
  input  logic [3:0]                            cmd_command,
  input  logic [3:0]                            cmd_address,
  input  logic [DATA_WIDTH-1:0]                 cmd_data,
  input  logic [2:0]                            cmd_device,
  output logic                                  sck,
  output logic                                  sdi,
  output logic                                  csb,
  output logic                                  busy,
  output logic                                  write_complete,
  output logic                                  bad_device,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_level
);

  localparam int FRAME_BITS = 24 * N_DEVICES;
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int LW         = $clog2(FIFO_DEPTH + 1);
  localparam int EW         = 11 + DATA_WIDTH;
  localparam int BW         = $clog2(FRAME_BITS);
  localparam int TMAX       = (SCK_DIV > CS_GAP) ? SCK_DIV : CS_GAP;
  localparam int TW         = $clog2(TMAX + 1);
  localparam logic [23:0] NOP_WORD = 24'hFF0000;

  if (!(DATA_WIDTH == 12 || DATA_WIDTH == 14 || DATA_WIDTH == 16)) begin : g_bad_width
    $error("DATA_WIDTH must be 12, 14 or 16");
  end
  if (N_DEVICES < 1 || N_DEVICES > 8) begin : g_bad_devices
    $error("N_DEVICES must be 1..8");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2, at least 2");
  end
  if (SCK_DIV < 1 || CS_GAP < 1) begin : g_bad_timing
    $error("SCK_DIV and CS_GAP must be at least 1");
  end

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, HOLD, GAP} state_t;

  state_t                  state, state_next;
  logic [EW-1:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]           wptr, rptr;
  logic [LW-1:0]           count;
  logic                    full, empty, push, pop;
  logic [EW-1:0]           head;
  logic                    head_bad;
  logic [EW-1:0]           cur;
  logic [2:0]              cur_dev;
  logic [3:0]              cur_cmd, cur_addr;
  logic [DATA_WIDTH-1:0]   cur_data;
  logic [15:0]             data16;
  logic [23:0]             cmd_word;
  logic [FRAME_BITS-1:0]   frame, shreg;
  logic [BW-1:0]           bit_idx;
  logic [TW-1:0]           timer;
  logic                    div_done, gap_done, last_bit;

  assign full     = (count == LW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign push     = cmd_valid && !full;
  assign pop      = (state == IDLE) && !empty;
  assign head     = mem[rptr];
  assign head_bad = {1'b0, head[EW-1 -: 3]} >= 4'(N_DEVICES);

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {cmd_device, cmd_command, cmd_address, cmd_data};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Popped entry is held here so the FIFO slot is free while the frame runs
  always_ff @(posedge clk) begin
    if (pop && !head_bad) cur <= head;
  end

  assign {cur_dev, cur_cmd, cur_addr, cur_data} = cur;
  assign data16   = 16'(cur_data) << (16 - DATA_WIDTH);
  assign cmd_word = {cur_cmd, cur_addr, data16};

  // Device 0 sits in the LSBs so it is shifted out last
  always_comb begin
    frame = '0;
    for (int unsigned i = 0; i < N_DEVICES; i++) begin
      frame[24*i +: 24] = (cur_dev == 3'(i)) ? cmd_word : NOP_WORD;
    end
  end

  assign div_done = (timer == TW'(SCK_DIV - 1));
  assign gap_done = (timer == TW'(CS_GAP - 1));
  assign last_bit = (bit_idx == BW'(FRAME_BITS - 1));

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (!empty && !head_bad) state_next = LOAD;
      LOAD:     state_next = SHIFT_LO;
      SHIFT_LO: if (div_done) state_next = SHIFT_HI;
      SHIFT_HI: if (div_done) state_next = last_bit ? HOLD : SHIFT_LO;
      HOLD:     if (div_done) state_next = GAP;
      GAP:      if (gap_done) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      timer <= (state_next != state || state == IDLE) ? '0 : timer + 1'b1;
      if (state == LOAD) begin
        shreg   <= frame;
        bit_idx <= '0;
      end else if (state == SHIFT_HI && div_done && !last_bit) begin
        shreg   <= shreg << 1;
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  always_comb begin
    csb            = 1'b1;
    sck            = 1'b0;
    sdi            = 1'b0;
    case (state)
      SHIFT_LO: begin
        csb = 1'b0;
        sdi = shreg[FRAME_BITS-1];
      end
      SHIFT_HI: begin
        csb = 1'b0;
        sck = 1'b1;
        sdi = shreg[FRAME_BITS-1];
      end
      HOLD: begin
        csb = 1'b0;
        sdi = shreg[FRAME_BITS-1];
      end
      default: ;
    endcase
    write_complete = (state == GAP) && (timer == '0);
    bad_device     = pop && head_bad;
    busy           = (state != IDLE) || !empty;
    cmd_ready      = !full;
    fifo_level     = count;
  end

endmodule

// File: tb/tb_ltc26xx_chain_writer.sv
// Directed bench for ltc26xx_chain_writer: three differently parameterised
// instances, a negedge SPI frame monitor and per-scenario check tasks.
module tb_ltc26xx_chain_writer;

  logic        clk = 1'b0;
  logic [2:0]  rstn;
  logic [2:0]  cmd_valid;
  logic [3:0]  cmd_command [3];
  logic [3:0]  cmd_address [3];
  logic [15:0] cmd_data    [3];
  logic [2:0]  cmd_device  [3];
  logic [2:0]  cmd_ready, sck, sdi, csb, busy, wc, bd;
  logic [3:0]  lvl0;
  logic [1:0]  lvl1;
  logic [2:0]  lvl2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ltc26xx_chain_writer #(.DATA_WIDTH(16), .N_DEVICES(1), .FIFO_DEPTH(8), .SCK_DIV(2), .CS_GAP(4)) u_single (
    .clk(clk), .rstn(rstn[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_command(cmd_command[0]), .cmd_address(cmd_address[0]), .cmd_data(cmd_data[0]),
    .cmd_device(cmd_device[0]), .sck(sck[0]), .sdi(sdi[0]), .csb(csb[0]), .busy(busy[0]),
    .write_complete(wc[0]), .bad_device(bd[0]), .fifo_level(lvl0));

  ltc26xx_chain_writer #(.DATA_WIDTH(12), .N_DEVICES(1), .FIFO_DEPTH(2), .SCK_DIV(1), .CS_GAP(1)) u_w12 (
    .clk(clk), .rstn(rstn[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_command(cmd_command[1]), .cmd_address(cmd_address[1]), .cmd_data(cmd_data[1][11:0]),
    .cmd_device(cmd_device[1]), .sck(sck[1]), .sdi(sdi[1]), .csb(csb[1]), .busy(busy[1]),
    .write_complete(wc[1]), .bad_device(bd[1]), .fifo_level(lvl1));

  ltc26xx_chain_writer #(.DATA_WIDTH(16), .N_DEVICES(2), .FIFO_DEPTH(4), .SCK_DIV(2), .CS_GAP(3)) u_chain (
    .clk(clk), .rstn(rstn[2]), .cmd_valid(cmd_valid[2]), .cmd_ready(cmd_ready[2]),
    .cmd_command(cmd_command[2]), .cmd_address(cmd_address[2]), .cmd_data(cmd_data[2]),
    .cmd_device(cmd_device[2]), .sck(sck[2]), .sdi(sdi[2]), .csb(csb[2]), .busy(busy[2]),
    .write_complete(wc[2]), .bad_device(bd[2]), .fifo_level(lvl2));

  // Frame monitor: bits captured on sck rise, frame recorded when csb rises
  logic [47:0] sh [3];
  int          nb [3], low [3], hi [3], gap_last [3];
  logic [2:0]  prev_csb = '1;
  logic [2:0]  prev_sck = '0;
  logic [47:0] fr_data [3][16];
  int          fr_bits [3][16], fr_low [3][16], fr_gap [3][16];
  logic        fr_wc   [3][16];
  int          fr_n [3], wc_cnt [3], bd_cnt [3];

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (csb[g] === 1'b0) begin
        hi[g] <= 0;
        if (prev_csb[g]) begin
          sh[g]       <= '0;
          nb[g]       <= 0;
          low[g]      <= 1;
          gap_last[g] <= hi[g];
        end else begin
          low[g] <= low[g] + 1;
          if (sck[g] && !prev_sck[g]) begin
            sh[g] <= {sh[g][46:0], sdi[g]};
            nb[g] <= nb[g] + 1;
          end
        end
      end else begin
        hi[g] <= hi[g] + 1;
        if (!prev_csb[g] && fr_n[g] < 16) begin
          fr_data[g][fr_n[g]] <= sh[g];
          fr_bits[g][fr_n[g]] <= nb[g];
          fr_low[g][fr_n[g]]  <= low[g];
          fr_gap[g][fr_n[g]]  <= gap_last[g];
          fr_wc[g][fr_n[g]]   <= wc[g];
          fr_n[g]             <= fr_n[g] + 1;
        end
      end
      prev_csb[g] <= csb[g];
      prev_sck[g] <= sck[g];
      if (wc[g] === 1'b1) wc_cnt[g] <= wc_cnt[g] + 1;
      if (bd[g] === 1'b1) bd_cnt[g] <= bd_cnt[g] + 1;
    end
  end

  function automatic int level(input int g);
    case (g)
      0:       return int'(lvl0);
      1:       return int'(lvl1);
      default: return int'(lvl2);
    endcase
  endfunction

  // One push attempt in one clock; fields are scrambled afterwards
  task automatic push(input int g, input logic [2:0] dev, input logic [3:0] cmd,
                      input logic [3:0] addr, input logic [15:0] data,
                      output bit acc, output int lvl);
    @(negedge clk);
    cmd_valid[g]   = 1'b1;
    cmd_device[g]  = dev;
    cmd_command[g] = cmd;
    cmd_address[g] = addr;
    cmd_data[g]    = data;
    acc            = cmd_ready[g];
    lvl            = level(g);
    @(posedge clk);
    #1;
    cmd_valid[g]   = 1'b0;
    cmd_device[g]  = 3'd6;
    cmd_command[g] = 4'hC;
    cmd_address[g] = 4'h7;
    cmd_data[g]    = 16'h5A5A;
  endtask

  task automatic wait_idle(input int g, input int budget);
    int k = 0;
    while (busy[g] !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (busy[g] !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout dut%0d: busy=%b, required 0 within %0d cycles", g, busy[g], budget);
    end
  endtask

  task automatic test_reset();
    rstn      = '0;
    cmd_valid = '0;
    for (int g = 0; g < 3; g++) begin
      cmd_command[g] = '0;
      cmd_address[g] = '0;
      cmd_data[g]    = '0;
      cmd_device[g]  = '0;
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({csb[0], sck[0], sdi[0], wc[0], bd[0], busy[0], cmd_ready[0], lvl0} !== {7'b1000001, 4'd0}) begin
      errors++;
      $display("FAIL reset_dut0: got %b, required %b", {csb[0], sck[0], sdi[0], wc[0], bd[0], busy[0], cmd_ready[0], lvl0}, {7'b1000001, 4'd0});
    end
    checks++;
    if ({csb[1], sck[1], sdi[1], wc[1], bd[1], busy[1], cmd_ready[1], lvl1} !== {7'b1000001, 2'd0}) begin
      errors++;
      $display("FAIL reset_dut1: got %b, required %b", {csb[1], sck[1], sdi[1], wc[1], bd[1], busy[1], cmd_ready[1], lvl1}, {7'b1000001, 2'd0});
    end
    checks++;
    if ({csb[2], sck[2], sdi[2], wc[2], bd[2], busy[2], cmd_ready[2], lvl2} !== {7'b1000001, 3'd0}) begin
      errors++;
      $display("FAIL reset_dut2: got %b, required %b", {csb[2], sck[2], sdi[2], wc[2], bd[2], busy[2], cmd_ready[2], lvl2}, {7'b1000001, 3'd0});
    end
    rstn = '1;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    bit acc;
    int lv, b, w;
    b = fr_n[0];
    w = wc_cnt[0];
    push(0, 3'd0, 4'h3, 4'h0, 16'hABCD, acc, lv);
    checks++;
    if (acc !== 1'b1 || lv != 0) begin
      errors++;
      $display("FAIL single_accept: ready=%b level=%0d, required 1 and 0", acc, lv);
    end
    wait_idle(0, 300);
    checks++;
    if (fr_n[0] != b + 1) begin
      errors++;
      $display("FAIL single_count: frames=%0d, required %0d", fr_n[0] - b, 1);
    end
    checks++;
    if (fr_data[0][b] !== 48'h30ABCD || fr_bits[0][b] != 24) begin
      errors++;
      $display("FAIL single_word: got %h/%0d bits, required 30abcd/24 bits", fr_data[0][b], fr_bits[0][b]);
    end
    checks++;
    if (fr_low[0][b] != 98) begin
      errors++;
      $display("FAIL single_csb_low: got %0d cycles, required 98", fr_low[0][b]);
    end
    checks++;
    if (fr_wc[0][b] !== 1'b1 || wc_cnt[0] != w + 1) begin
      errors++;
      $display("FAIL single_complete: at csb rise %b, pulses %0d, required 1 and 1", fr_wc[0][b], wc_cnt[0] - w);
    end
  endtask

  task automatic test_justify_12();
    bit acc;
    int lv, b;
    b = fr_n[1];
    push(1, 3'd0, 4'h3, 4'h2, 16'h0FFF, acc, lv);
    wait_idle(1, 200);
    checks++;
    if (fr_n[1] != b + 1 || fr_data[1][b] !== 48'h32FFF0 || fr_bits[1][b] != 24) begin
      errors++;
      $display("FAIL justify12_word: got %h/%0d bits, required 32fff0/24 bits", fr_data[1][b], fr_bits[1][b]);
    end
    checks++;
    if (fr_low[1][b] != 49 || fr_wc[1][b] !== 1'b1) begin
      errors++;
      $display("FAIL justify12_timing: csb low %0d wc %b, required 49 and 1", fr_low[1][b], fr_wc[1][b]);
    end
  endtask

  task automatic test_daisy_chain();
    bit acc;
    int lv, b;
    b = fr_n[2];
    push(2, 3'd0, 4'h3, 4'h1, 16'h1234, acc, lv);
    push(2, 3'd1, 4'h3, 4'h1, 16'h1234, acc, lv);
    wait_idle(2, 1000);
    checks++;
    if (fr_n[2] != b + 2) begin
      errors++;
      $display("FAIL chain_count: frames=%0d, required 2", fr_n[2] - b);
    end
    checks++;
    if (fr_data[2][b] !== 48'hFF0000_311234 || fr_bits[2][b] != 48 || fr_low[2][b] != 194) begin
      errors++;
      $display("FAIL chain_dev0: got %h/%0d bits/%0d low, required ff0000311234/48/194", fr_data[2][b], fr_bits[2][b], fr_low[2][b]);
    end
    checks++;
    if (fr_data[2][b+1] !== 48'h311234_FF0000 || fr_bits[2][b+1] != 48 || fr_low[2][b+1] != 194) begin
      errors++;
      $display("FAIL chain_dev1: got %h/%0d bits/%0d low, required 311234ff0000/48/194", fr_data[2][b+1], fr_bits[2][b+1], fr_low[2][b+1]);
    end
    checks++;
    if (fr_gap[2][b+1] != 5) begin
      errors++;
      $display("FAIL chain_gap: csb high %0d cycles, required 5", fr_gap[2][b+1]);
    end
  endtask

  task automatic test_bad_device();
    bit acc;
    int lv, b, bb, w;
    b  = fr_n[2];
    bb = bd_cnt[2];
    w  = wc_cnt[2];
    push(2, 3'd5, 4'h3, 4'h1, 16'h1234, acc, lv);
    push(2, 3'd1, 4'h2, 4'h3, 16'hBEEF, acc, lv);
    wait_idle(2, 600);
    checks++;
    if (bd_cnt[2] != bb + 1) begin
      errors++;
      $display("FAIL bad_pulse: pulses=%0d, required 1", bd_cnt[2] - bb);
    end
    checks++;
    if (fr_n[2] != b + 1 || wc_cnt[2] != w + 1) begin
      errors++;
      $display("FAIL bad_frames: frames=%0d completes=%0d, required 1 and 1", fr_n[2] - b, wc_cnt[2] - w);
    end
    checks++;
    if (fr_data[2][b] !== 48'h23BEEF_FF0000) begin
      errors++;
      $display("FAIL bad_next_word: got %h, required 23beefff0000", fr_data[2][b]);
    end
  endtask

  task automatic test_back_to_back();
    bit acc;
    int lv, b, k;
    logic [47:0] exp;
    b = fr_n[2];
    push(2, 3'd0, 4'h3, 4'hF, 16'hCAFE, acc, lv);
    k = 0;
    while (csb[2] !== 1'b0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (csb[2] !== 1'b0) begin
      errors++;
      $display("FAIL bp_start: csb=%b, required 0 within 20 cycles", csb[2]);
    end
    for (int i = 0; i < 6; i++) begin
      push(2, 3'd0, 4'h3, 4'(i), 16'h1000 + 16'(i), acc, lv);
      checks++;
      if (acc !== (i < 4) || lv != ((i < 4) ? i : 4)) begin
        errors++;
        $display("FAIL bp_attempt%0d: ready=%b level=%0d, required %b and %0d", i, acc, lv, (i < 4), (i < 4) ? i : 4);
      end
    end
    wait_idle(2, 2000);
    checks++;
    if (fr_n[2] != b + 5) begin
      errors++;
      $display("FAIL bp_count: frames=%0d, required 5", fr_n[2] - b);
    end
    checks++;
    if (fr_data[2][b] !== 48'hFF0000_3FCAFE) begin
      errors++;
      $display("FAIL bp_first: got %h, required ff00003fcafe", fr_data[2][b]);
    end
    for (int i = 0; i < 4; i++) begin
      exp = {24'hFF0000, 4'h3, 4'(i), 16'h1000 + 16'(i)};
      checks++;
      if (fr_data[2][b+1+i] !== exp || fr_gap[2][b+1+i] != 5) begin
        errors++;
        $display("FAIL bp_frame%0d: got %h gap %0d, required %h gap 5", i, fr_data[2][b+1+i], fr_gap[2][b+1+i], exp);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit acc;
    int lv, b, w, k;
    b = fr_n[0];
    push(0, 3'd0, 4'h3, 4'h5, 16'h1357, acc, lv);
    push(0, 3'd0, 4'h3, 4'h6, 16'h2468, acc, lv);
    k = 0;
    while (!(nb[0] == 10 && csb[0] === 1'b0) && k < 200) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (nb[0] != 10) begin
      errors++;
      $display("FAIL rst_bit10: bits=%0d, required 10 within 200 cycles", nb[0]);
    end
    w       = wc_cnt[0];
    rstn[0] = 1'b0;
    @(negedge clk);
    checks++;
    if ({csb[0], sck[0], sdi[0], wc[0], busy[0], lvl0} !== {5'b10000, 4'd0}) begin
      errors++;
      $display("FAIL rst_abort: got %b, required %b", {csb[0], sck[0], sdi[0], wc[0], busy[0], lvl0}, {5'b10000, 4'd0});
    end
    rstn[0] = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (fr_n[0] != b + 1 || fr_wc[0][b] !== 1'b0 || wc_cnt[0] != w || csb[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_quiet: frames=%0d wc=%0d csb=%b, required 1 aborted, 0, 1", fr_n[0] - b, wc_cnt[0] - w, csb[0]);
    end
    b = fr_n[0];
    push(0, 3'd0, 4'h3, 4'h0, 16'h0F0F, acc, lv);
    wait_idle(0, 300);
    checks++;
    if (fr_n[0] != b + 1 || fr_data[0][b] !== 48'h300F0F || fr_bits[0][b] != 24 || fr_wc[0][b] !== 1'b1) begin
      errors++;
      $display("FAIL rst_after: got %h/%0d bits wc %b, required 300f0f/24 bits wc 1", fr_data[0][b], fr_bits[0][b], fr_wc[0][b]);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_justify_12();
    test_daisy_chain();
    test_bad_device();
    test_back_to_back();
    test_reset_mid_frame();
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
